// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcodes, mul/div opcodes, and mul/div latency.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_OR  = 4'h3,
    ALU_XOR = 4'h4,
    ALU_SLT = 4'h5
  } aluop_t;

  typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} muldiv_op_t;

  // Cycles from the start cycle to the done cycle.
  localparam int unsigned MULDIV_LAT = 35;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer producing HI/LO.
// Borrows the shared ALU (add/sub) for 32 iteration cycles.
module muldiv_seq
  import cpu_types_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  muldiv_op_t       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             alu_own,
  output aluop_t           alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [2:0] {StIdle, StCapt, StIter, StFix, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  muldiv_op_t       op_q;
  logic             neg_res_q, neg_rem_q;
  // Mult: acc = product high, sh = multiplier/product low, opb = multiplicand.
  // Div:  acc = remainder,    sh = dividend/quotient,      opb = divisor.
  logic [WIDTH-1:0] acc_q, sh_q, opb_q, hi_q, lo_q;

  logic               accept, is_div, is_signed, in_iter, last_iter, ge, carry;
  logic [WIDTH-1:0]   rem_sh, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod, prod_fix;

  // flush beats a coincident start
  assign accept    = (state_q == StIdle || state_q == StDone) && start && !flush;
  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU);
  assign is_signed = (op_q == MD_MULT) || (op_q == MD_DIV);
  assign in_iter   = (state_q == StIter);
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign rem_sh    = {acc_q[WIDTH-2:0], sh_q[WIDTH-1]};
  assign ge        = (rem_sh >= opb_q);
  assign carry     = (alu_out < acc_q);

  assign prod     = {acc_q, sh_q};
  assign prod_fix = neg_res_q ? -prod : prod;
  assign quo_fix  = neg_res_q ? -sh_q : sh_q;
  assign rem_fix  = neg_rem_q ? -acc_q : acc_q;

  assign busy = (state_q == StCapt) || in_iter || (state_q == StFix);
  assign done = (state_q == StDone);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Next state: flush aborts any busy state back to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StCapt;
      StDone:  state_d = accept ? StCapt : StIdle;
      StCapt:  state_d = flush ? StIdle : StIter;
      StIter: begin
        if (flush) state_d = StIdle;
        else if (last_iter) state_d = StFix;
      end
      StFix:   state_d = flush ? StIdle : StDone;
      default: state_d = StIdle;
    endcase
  end

  // Drive the shared ALU only while iterating
  always_comb begin
    alu_own = in_iter;
    alu_op  = ALU_ADD;
    alu_a   = '0;
    alu_b   = '0;
    if (in_iter) begin
      if (is_div) begin
        alu_op = ALU_SUB;
        alu_a  = rem_sh;
        alu_b  = opb_q;
      end else begin
        alu_a = acc_q;
        alu_b = sh_q[0] ? opb_q : '0;
      end
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Operand capture, iteration datapath and result write-back
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q     <= '0;
      op_q      <= MD_MULT;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      acc_q     <= '0;
      sh_q      <= '0;
      opb_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else if (accept) begin
      op_q  <= op;
      // Dividend goes in the shifter; for mult the multiplier does
      sh_q  <= op[1] ? a : b;
      opb_q <= op[1] ? b : a;
    end else begin
      unique case (state_q)
        StCapt: begin
          // Negation leaves 0x80000000 as the correct unsigned magnitude
          neg_res_q <= is_signed & (sh_q[WIDTH-1] ^ opb_q[WIDTH-1]);
          neg_rem_q <= is_signed & sh_q[WIDTH-1];
          sh_q      <= (is_signed && sh_q[WIDTH-1]) ? -sh_q : sh_q;
          opb_q     <= (is_signed && opb_q[WIDTH-1]) ? -opb_q : opb_q;
          acc_q     <= '0;
          cnt_q     <= '0;
        end
        StIter: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (is_div) begin
            // acc[31] set means the shifted remainder overflowed 32 bits
            if (acc_q[WIDTH-1] || ge) begin
              acc_q <= alu_out;
              sh_q  <= {sh_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_q <= rem_sh;
              sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_q <= {carry, alu_out[WIDTH-1:1]};
            sh_q  <= {alu_out[0], sh_q[WIDTH-1:1]};
          end
        end
        StFix: begin
          if (!flush) begin
            if (is_div) begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq with a behavioural ALU.
module tb_muldiv_seq;
  import cpu_types_pkg::*;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       start = 1'b0;
  muldiv_op_t op = MD_MULT;
  word_t      a = '0;
  word_t      b = '0;
  logic       flush = 1'b0;
  logic       alu_own, busy, done;
  aluop_t     alu_op;
  word_t      alu_a, alu_b, alu_out, hi, lo;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 CLK = ~CLK;

  // Shared combinational ALU
  assign alu_out = (alu_op == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

  muldiv_seq dut (
    .CLK     (CLK),
    .RST     (RST),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .alu_own (alu_own),
    .alu_op  (alu_op),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_out (alu_out),
    .busy    (busy),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance from cycle count n0 until done is seen or the budget runs out
  task automatic wait_done(input int n0, output int n);
    n = n0;
    while (!done && n < 60) begin
      @(posedge CLK); #1;
      n++;
    end
  endtask

  // Called at #1 after an edge; returns at #1 into the done cycle
  task automatic do_op(input string tag, input muldiv_op_t o, input word_t x, input word_t y,
                       input word_t exp_hi, input word_t exp_lo);
    int n;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge CLK); #1;
    start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D;
    wait_done(1, n);
    check_eq({tag, "_lat"}, n, MULDIV_LAT);
    check_eq({tag, "_hi"}, hi, exp_hi);
    check_eq({tag, "_lo"}, lo, exp_lo);
  endtask

  task automatic check_reset_outs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_own"}, alu_own, 0);
    check_eq({tag, "_aluop"}, alu_op, ALU_ADD);
    check_eq({tag, "_alua"}, alu_a, 0);
    check_eq({tag, "_alub"}, alu_b, 0);
    check_eq({tag, "_hi"}, hi, 0);
    check_eq({tag, "_lo"}, lo, 0);
  endtask

  initial begin
    int n;
    int seen;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outs("rst");
    RST = 1'b0;
    @(posedge CLK); #1;

    // Back-to-back chain: each op starts in the previous op's done cycle
    do_op("multu_max", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    do_op("mult_neg", MD_MULT, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    do_op("mult_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0);
    do_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu", MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3);
    do_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    do_op("divu_z", MD_DIVU, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF);

    // done is a single pulse and results hold afterwards
    @(posedge CLK); #1;
    check_eq("done_pulse", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("hold_lo", lo, 32'hFFFF_FFFF);

    // start while busy is ignored
    start = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd3;
    @(posedge CLK); #1;
    start = 1'b0;
    n = 1;
    repeat (5) begin @(posedge CLK); #1; n++; end
    check_eq("iter_busy", busy, 1);
    check_eq("iter_own", alu_own, 1);
    start = 1'b1; op = MD_DIVU; a = 32'd100; b = 32'd7;
    @(posedge CLK); #1;
    n++;
    start = 1'b0;
    wait_done(n, n);
    check_eq("ign_lat", n, MULDIV_LAT);
    check_eq("ign_hi", hi, 32'd0);
    check_eq("ign_lo", lo, 32'd6);
    @(posedge CLK); #1;

    // start together with flush in idle launches nothing
    start = 1'b1; flush = 1'b1; op = MD_MULTU; a = 32'd9; b = 32'd9;
    @(posedge CLK); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("sf_busy", busy, 0);

    // flush in the 10th iteration cycle
    start = 1'b1; op = MD_MULTU; a = 32'd5; b = 32'd5;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    check_eq("fl_own", alu_own, 1);
    flush = 1'b1;
    @(posedge CLK); #1;
    flush = 1'b0;
    check_eq("fl_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      @(posedge CLK); #1;
      if (done) seen = 1;
    end
    check_eq("fl_nodone", seen, 0);
    check_eq("fl_hi", hi, 32'd0);
    check_eq("fl_lo", lo, 32'd6);
    do_op("post_fl", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    @(posedge CLK); #1;

    // asynchronous reset mid-iteration
    start = 1'b1; op = MD_MULTU; a = 32'd3; b = 32'd4;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    check_eq("pre_rst_own", alu_own, 1);
    RST = 1'b1;
    #1;
    check_reset_outs("arst");
    RST = 1'b0;
    @(posedge CLK); #1;
    check_eq("arst_idle", busy, 0);
    do_op("post_rst", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
